// File: rtl/l2_arbiter.sv
// Two-client arbiter merging L1 I-cache and D-cache line requests onto the L2 port.
// Each granted request is latched and held stable until L2 signals completion.
module l2_arbiter #(
  parameter int ADDR_W      = 16,
  parameter int LINE_W      = 128,
  parameter int ROUND_ROBIN = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_mem_read,
  input  logic [ADDR_W-1:0] i_mem_address,
  output logic              i_mem_resp,
  output logic [LINE_W-1:0] i_mem_rdata,
  input  logic              d_mem_read,
  input  logic              d_mem_write,
  input  logic [ADDR_W-1:0] d_mem_address,
  input  logic [LINE_W-1:0] d_mem_wdata,
  output logic              d_mem_resp,
  output logic [LINE_W-1:0] d_mem_rdata,
  output logic              l2_mem_read,
  output logic              l2_mem_write,
  output logic [ADDR_W-1:0] l2_mem_address,
  output logic [LINE_W-1:0] l2_mem_wdata,
  input  logic              l2_mem_resp,
  input  logic [LINE_W-1:0] l2_mem_rdata
);

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;

  localparam logic RR = (ROUND_ROBIN != 0);

  state_t            r_state;
  logic              r_last_grant;
  logic              r_l2_read;
  logic              r_l2_write;
  logic [ADDR_W-1:0] r_l2_address;
  logic [LINE_W-1:0] r_l2_wdata;

  logic w_i_req;
  logic w_d_req;
  logic w_tie_to_d;
  logic w_grant_d;
  logic w_grant_i;

  assign w_i_req    = i_mem_read;
  assign w_d_req    = d_mem_read | d_mem_write;
  // On a tie D wins under fixed priority, or when I was the last client served.
  assign w_tie_to_d = ~RR | ~r_last_grant;
  assign w_grant_d  = w_d_req & (~w_i_req | w_tie_to_d);
  assign w_grant_i  = w_i_req & ~w_grant_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_last_grant <= 1'b1;
      r_l2_read    <= 1'b0;
      r_l2_write   <= 1'b0;
      r_l2_address <= '0;
      r_l2_wdata   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant_d) begin
            // A simultaneous read and write from D is treated as a write.
            r_l2_read    <= d_mem_read & ~d_mem_write;
            r_l2_write   <= d_mem_write;
            r_l2_address <= d_mem_address;
            r_l2_wdata   <= d_mem_wdata;
            r_last_grant <= 1'b1;
            r_state      <= SERVE_D;
          end else if (w_grant_i) begin
            r_l2_read    <= 1'b1;
            r_l2_write   <= 1'b0;
            r_l2_address <= i_mem_address;
            r_last_grant <= 1'b0;
            r_state      <= SERVE_I;
          end
        end
        SERVE_I, SERVE_D: begin
          if (l2_mem_resp) begin
            r_l2_read  <= 1'b0;
            r_l2_write <= 1'b0;
            r_state    <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign l2_mem_read    = r_l2_read;
  assign l2_mem_write   = r_l2_write;
  assign l2_mem_address = r_l2_address;
  assign l2_mem_wdata   = r_l2_wdata;

  assign i_mem_resp  = (r_state == SERVE_I) & l2_mem_resp;
  assign d_mem_resp  = (r_state == SERVE_D) & l2_mem_resp;
  assign i_mem_rdata = l2_mem_rdata;
  assign d_mem_rdata = l2_mem_rdata;

endmodule

// File: tb/tb_l2_arbiter.sv
// Scoreboard bench for l2_arbiter: a round-robin instance driven by directed
// transactions against an L2 model, plus a fixed-priority instance.
module tb_l2_arbiter;

  logic         clk;
  logic         reset_n;
  logic         i_mem_read;
  logic [15:0]  i_mem_address;
  logic         i_mem_resp;
  logic [127:0] i_mem_rdata;
  logic         d_mem_read, d_mem_write;
  logic [15:0]  d_mem_address;
  logic [127:0] d_mem_wdata;
  logic         d_mem_resp;
  logic [127:0] d_mem_rdata;
  logic         l2_mem_read, l2_mem_write;
  logic [15:0]  l2_mem_address;
  logic [127:0] l2_mem_wdata;
  logic         l2_mem_resp;
  logic [127:0] l2_mem_rdata;

  logic         fp_i_mem_read;
  logic [15:0]  fp_i_mem_address;
  logic         fp_i_mem_resp;
  logic [127:0] fp_i_mem_rdata;
  logic         fp_d_mem_read, fp_d_mem_write;
  logic [15:0]  fp_d_mem_address;
  logic [127:0] fp_d_mem_wdata;
  logic         fp_d_mem_resp;
  logic [127:0] fp_d_mem_rdata;
  logic         fp_l2_mem_read, fp_l2_mem_write;
  logic [15:0]  fp_l2_mem_address;
  logic [127:0] fp_l2_mem_wdata;
  logic         fp_l2_mem_resp;
  logic [127:0] fp_l2_mem_rdata;

  l2_arbiter #(.ADDR_W(16), .LINE_W(128), .ROUND_ROBIN(1)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_mem_read(i_mem_read), .i_mem_address(i_mem_address),
    .i_mem_resp(i_mem_resp), .i_mem_rdata(i_mem_rdata),
    .d_mem_read(d_mem_read), .d_mem_write(d_mem_write),
    .d_mem_address(d_mem_address), .d_mem_wdata(d_mem_wdata),
    .d_mem_resp(d_mem_resp), .d_mem_rdata(d_mem_rdata),
    .l2_mem_read(l2_mem_read), .l2_mem_write(l2_mem_write),
    .l2_mem_address(l2_mem_address), .l2_mem_wdata(l2_mem_wdata),
    .l2_mem_resp(l2_mem_resp), .l2_mem_rdata(l2_mem_rdata)
  );

  l2_arbiter #(.ADDR_W(16), .LINE_W(128), .ROUND_ROBIN(0)) dut_fp (
    .clk(clk), .reset_n(reset_n),
    .i_mem_read(fp_i_mem_read), .i_mem_address(fp_i_mem_address),
    .i_mem_resp(fp_i_mem_resp), .i_mem_rdata(fp_i_mem_rdata),
    .d_mem_read(fp_d_mem_read), .d_mem_write(fp_d_mem_write),
    .d_mem_address(fp_d_mem_address), .d_mem_wdata(fp_d_mem_wdata),
    .d_mem_resp(fp_d_mem_resp), .d_mem_rdata(fp_d_mem_rdata),
    .l2_mem_read(fp_l2_mem_read), .l2_mem_write(fp_l2_mem_write),
    .l2_mem_address(fp_l2_mem_address), .l2_mem_wdata(fp_l2_mem_wdata),
    .l2_mem_resp(fp_l2_mem_resp), .l2_mem_rdata(fp_l2_mem_rdata)
  );

  typedef struct {
    bit           is_d;
    bit           wr;
    logic [15:0]  addr;
    logic [127:0] wdata;
    logic [127:0] rdata;
  } txn_t;

  txn_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   l2_delay;
  int   l2_cnt;
  bit   force_resp;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [127:0] rdata_for(input logic [15:0] a);
    if (a == 16'h1230) return {16{8'hA5}};
    return {8{a}};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input bit is_d, input bit wr, input logic [15:0] a, input logic [127:0] wd);
    txn_t t;
    t.is_d = is_d; t.wr = wr; t.addr = a; t.wdata = wd; t.rdata = rdata_for(a);
    sb.push_back(t);
  endtask

  // Returns the cycle in which the selected client's resp was seen.
  task automatic wait_resp(input bit is_d, output int at);
    bit found = 0;
    at = -1;
    for (int k = 0; k < 30 && !found; k++) begin
      @(negedge clk); #1;
      if (is_d ? d_mem_resp : i_mem_resp) begin
        found = 1;
        at = cyc;
      end
    end
    chk(is_d ? "d_resp_timeout" : "i_resp_timeout", found, 1'b1);
  endtask

  // L2 model: resp after l2_delay cycles of an active request; fp instance always hits.
  initial begin
    l2_mem_resp = 0; l2_mem_rdata = '0; l2_cnt = 0;
    fp_l2_mem_resp = 0; fp_l2_mem_rdata = {8{16'hF00D}};
    forever begin
      @(negedge clk);
      if (l2_mem_read || l2_mem_write) begin
        l2_mem_resp = (l2_cnt == l2_delay);
        l2_cnt++;
      end else begin
        l2_mem_resp = force_resp;
        l2_cnt = 0;
      end
      l2_mem_rdata   = rdata_for(l2_mem_address);
      fp_l2_mem_resp = fp_l2_mem_read | fp_l2_mem_write;
    end
  end

  // Monitor: every resp pulse must match the oldest expected transaction.
  initial begin
    txn_t e;
    forever begin
      @(negedge clk); #2;
      if (i_mem_resp || d_mem_resp) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_resp: got i=%0b d=%0b expected none (cycle %0d)", i_mem_resp, d_mem_resp, cyc);
        end else begin
          e = sb.pop_front();
          $display("txn cycle %0d: %s %s addr=%h", cyc, e.is_d ? "D" : "I", e.wr ? "write" : "read", e.addr);
          chk("resp_d_client", d_mem_resp, e.is_d);
          chk("resp_i_client", i_mem_resp, !e.is_d);
          chk("l2_address", l2_mem_address, e.addr);
          chk("l2_read", l2_mem_read, !e.wr);
          chk("l2_write", l2_mem_write, e.wr);
          if (e.wr) chk("l2_wdata", l2_mem_wdata, e.wdata);
          else      chk("rdata", e.is_d ? d_mem_rdata : i_mem_rdata, e.rdata);
        end
      end
    end
  end

  initial begin
    int c0, ci, cd, nd, ni;
    bit found;
    reset_n = 0; l2_delay = 0; force_resp = 0;
    i_mem_read = 0; i_mem_address = '0;
    d_mem_read = 0; d_mem_write = 0; d_mem_address = '0; d_mem_wdata = '0;
    fp_i_mem_read = 0; fp_i_mem_address = 16'h0100;
    fp_d_mem_read = 0; fp_d_mem_write = 0; fp_d_mem_address = 16'h0200; fp_d_mem_wdata = '0;

    #12;
    chk("rst_l2_read", l2_mem_read, 1'b0);
    chk("rst_l2_write", l2_mem_write, 1'b0);
    chk("rst_l2_address", l2_mem_address, 16'h0);
    chk("rst_l2_wdata", l2_mem_wdata, 128'h0);
    chk("rst_i_resp", i_mem_resp, 1'b0);
    chk("rst_d_resp", d_mem_resp, 1'b0);
    @(negedge clk); reset_n = 1;

    // First tie after reset goes to I; D follows two cycles after I's resp.
    @(negedge clk);
    i_mem_read = 1; i_mem_address = 16'h2000;
    d_mem_write = 1; d_mem_address = 16'h4000; d_mem_wdata = {8{16'h1111}};
    push(0, 0, 16'h2000, '0);
    push(1, 1, 16'h4000, {8{16'h1111}});
    wait_resp(0, ci); i_mem_read = 0;
    wait_resp(1, cd); d_mem_write = 0;
    chk("d_after_i_gap", cd, ci + 2);

    // Single I read, L2 hit: request and resp in the cycle after sampling.
    @(negedge clk);
    i_mem_read = 1; i_mem_address = 16'h1230;
    push(0, 0, 16'h1230, '0);
    @(posedge clk); #1;
    c0 = cyc;
    chk("hit_l2_read", l2_mem_read, 1'b1);
    chk("hit_l2_address", l2_mem_address, 16'h1230);
    chk("hit_l2_write", l2_mem_write, 1'b0);
    wait_resp(0, ci); i_mem_read = 0;
    chk("hit_same_cycle", ci, c0);

    // Tie after I was last served: D wins.
    @(negedge clk);
    i_mem_read = 1; i_mem_address = 16'h2000;
    d_mem_write = 1; d_mem_address = 16'h4000; d_mem_wdata = {8{16'h2222}};
    push(1, 1, 16'h4000, {8{16'h2222}});
    push(0, 0, 16'h2000, '0);
    wait_resp(1, cd); d_mem_write = 0;
    wait_resp(0, ci); i_mem_read = 0;

    // Long L2 stall; client drops its request mid-way, request must hold.
    @(negedge clk);
    d_mem_read = 1; d_mem_address = 16'h5550; l2_delay = 20;
    push(1, 0, 16'h5550, '0);
    @(posedge clk); #1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk); #1;
      if (k == 5) d_mem_read = 0;
      chk("stall_l2_read", l2_mem_read, 1'b1);
      chk("stall_l2_address", l2_mem_address, 16'h5550);
      chk("stall_d_resp", d_mem_resp, 1'b0);
    end
    wait_resp(1, cd);
    l2_delay = 0;
    @(negedge clk); #1;
    chk("stall_resp_single", d_mem_resp, 1'b0);

    // Async reset during SERVE_D, in the very cycle L2 responds.
    @(negedge clk);
    d_mem_read = 1; d_mem_address = 16'h6000; l2_delay = 3;
    found = 0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(negedge clk); #1;
      if (l2_mem_resp) found = 1;
    end
    chk("rstmid_l2_resp_seen", found, 1'b1);
    reset_n = 0; d_mem_read = 0;
    #1;
    chk("rstmid_l2_read", l2_mem_read, 1'b0);
    chk("rstmid_l2_write", l2_mem_write, 1'b0);
    chk("rstmid_d_resp", d_mem_resp, 1'b0);
    @(negedge clk); reset_n = 1; l2_delay = 0;

    // Tie after reset release goes to I.
    @(negedge clk);
    i_mem_read = 1; i_mem_address = 16'h7000;
    d_mem_read = 1; d_mem_address = 16'h7100;
    push(0, 0, 16'h7000, '0);
    push(1, 0, 16'h7100, '0);
    wait_resp(0, ci); i_mem_read = 0;
    wait_resp(1, cd); d_mem_read = 0;

    // L2 resp while IDLE is ignored.
    @(negedge clk); force_resp = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      chk("idle_i_resp", i_mem_resp, 1'b0);
      chk("idle_d_resp", d_mem_resp, 1'b0);
      chk("idle_l2_read", l2_mem_read, 1'b0);
    end
    force_resp = 0;
    @(negedge clk);
    i_mem_read = 1; i_mem_address = 16'h1230;
    push(0, 0, 16'h1230, '0);
    @(posedge clk); #1;
    chk("post_idle_l2_read", l2_mem_read, 1'b1);
    wait_resp(0, ci); i_mem_read = 0;
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);

    // Fixed priority: D wins every tie; I only once D goes idle.
    @(negedge clk);
    fp_i_mem_read = 1; fp_d_mem_read = 1;
    nd = 0; ni = 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk); #1;
      if (fp_d_mem_resp) begin
        nd++;
        chk("fp_d_address", fp_l2_mem_address, 16'h0200);
      end
      if (fp_i_mem_resp) ni++;
    end
    chk("fp_d_grants", nd, 8);
    chk("fp_i_grants", ni, 0);
    fp_d_mem_read = 0;
    found = 0;
    for (int k = 0; k < 6 && !found; k++) begin
      @(negedge clk); #1;
      if (fp_i_mem_resp) begin
        found = 1;
        chk("fp_i_address", fp_l2_mem_address, 16'h0100);
      end
    end
    chk("fp_i_served", found, 1'b1);
    fp_i_mem_read = 0;

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
